// File: rtl/coord_scan_ctrl.sv
// coord_scan_ctrl: raster-scan coordinate sequencer with a user cursor and confirm/lock hold.
// Build option: define CURSOR_WRAP_EN to make the cursor wrap at matrix edges (default saturates).
module coord_scan_ctrl #(
   parameter int N_COL   = 5,
   parameter int N_ROW   = 7,
   parameter int DIV     = 50000,
   parameter int LOCK_TK = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       en,
   input  logic       btn_up,
   input  logic       btn_dn,
   input  logic       btn_lf,
   input  logic       btn_rt,
   input  logic       sel_req,
   output logic [2:0] mdc,
   output logic [2:0] mdl,
   output logic [2:0] cur_c,
   output logic [2:0] cur_r,
   output logic       scan_valid,
   output logic       frame_done,
   output logic       sel_ack,
   output logic       locked
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int LW = (LOCK_TK > 1) ? $clog2(LOCK_TK) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_TK - 1);
   localparam logic [2:0]    COL_LAST   = 3'(N_COL - 1);
   localparam logic [2:0]    ROW_LAST   = 3'(N_ROW - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_LOCK = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [LW-1:0] lock_cnt_q, lock_cnt_d;
   logic [2:0]    scan_c_q, scan_c_d;
   logic [2:0]    scan_r_q, scan_r_d;
   logic [2:0]    mdc_q, mdc_d;
   logic [2:0]    mdl_q, mdl_d;
   logic [2:0]    cur_c_q, cur_c_d;
   logic [2:0]    cur_r_q, cur_r_d;
   logic          scan_valid_q, scan_valid_d;
   logic          frame_done_q, frame_done_d;
   logic          sel_ack_q, sel_ack_d;
   logic          sel_pend_q, sel_pend_d;

   logic       tick;
   logic       btn_any;
   logic       sel_go;
   logic [2:0] nxt_c, nxt_r;
   logic       frame_wrap;

   function automatic logic [2:0] cur_inc(input logic [2:0] v, input logic [2:0] last);
`ifdef CURSOR_WRAP_EN
      return (v == last) ? 3'd0 : v + 3'd1;
`else
      return (v == last) ? last : v + 3'd1;
`endif
   endfunction

   function automatic logic [2:0] cur_dec(input logic [2:0] v, input logic [2:0] last);
`ifdef CURSOR_WRAP_EN
      return (v == 3'd0) ? last : v - 3'd1;
`else
      return (v == 3'd0) ? 3'd0 : v - 3'd1;
`endif
   endfunction

   assign tick    = (state_q != ST_IDLE) && (presc_q == PRESC_LAST);
   assign btn_any = btn_up | btn_dn | btn_lf | btn_rt;
   // A confirm that coincides with a move waits one cycle so LOCK shows the moved cursor.
   assign sel_go  = sel_pend_q | (sel_req & ~btn_any);

   always_comb begin
      nxt_c      = scan_c_q;
      nxt_r      = scan_r_q;
      frame_wrap = 1'b0;
      if (scan_c_q == COL_LAST) begin
         nxt_c = 3'd0;
         if (scan_r_q == ROW_LAST) begin
            nxt_r      = 3'd0;
            frame_wrap = 1'b1;
         end else begin
            nxt_r = scan_r_q + 3'd1;
         end
      end else begin
         nxt_c = scan_c_q + 3'd1;
      end
   end

   always_comb begin
      cur_c_d = cur_c_q;
      cur_r_d = cur_r_q;
      if (state_q != ST_LOCK) begin
         if (btn_up)      cur_r_d = cur_dec(cur_r_q, ROW_LAST);
         else if (btn_dn) cur_r_d = cur_inc(cur_r_q, ROW_LAST);
         else if (btn_lf) cur_c_d = cur_dec(cur_c_q, COL_LAST);
         else if (btn_rt) cur_c_d = cur_inc(cur_c_q, COL_LAST);
      end
   end

   // NOTE: every next-state signal is given its hold value first so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      presc_d      = presc_q;
      lock_cnt_d   = lock_cnt_q;
      scan_c_d     = scan_c_q;
      scan_r_d     = scan_r_q;
      mdc_d        = mdc_q;
      mdl_d        = mdl_q;
      scan_valid_d = scan_valid_q;
      frame_done_d = 1'b0;
      sel_ack_d    = 1'b0;
      sel_pend_d   = 1'b0;

      if (!en) begin
         state_d      = ST_IDLE;
         presc_d      = '0;
         lock_cnt_d   = '0;
         scan_c_d     = 3'd0;
         scan_r_d     = 3'd0;
         mdc_d        = 3'd0;
         mdl_d        = 3'd0;
         scan_valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d      = ST_SCAN;
               presc_d      = '0;
               scan_c_d     = 3'd0;
               scan_r_d     = 3'd0;
               mdc_d        = 3'd0;
               mdl_d        = 3'd0;
               scan_valid_d = 1'b1;
            end
            ST_SCAN: begin
               if (sel_go) begin
                  // Scan position is frozen here and resumed unchanged after LOCK.
                  state_d      = ST_LOCK;
                  presc_d      = '0;
                  lock_cnt_d   = '0;
                  mdc_d        = cur_c_q;
                  mdl_d        = cur_r_q;
                  scan_valid_d = 1'b0;
                  sel_ack_d    = 1'b1;
               end else begin
                  sel_pend_d = sel_req & btn_any;
                  presc_d    = tick ? '0 : presc_q + 1'b1;
                  if (tick) begin
                     scan_c_d     = nxt_c;
                     scan_r_d     = nxt_r;
                     mdc_d        = nxt_c;
                     mdl_d        = nxt_r;
                     frame_done_d = frame_wrap;
                  end
               end
            end
            ST_LOCK: begin
               presc_d = tick ? '0 : presc_q + 1'b1;
               if (tick) begin
                  if (lock_cnt_q == LOCK_LAST) begin
                     state_d      = ST_SCAN;
                     lock_cnt_d   = '0;
                     mdc_d        = scan_c_q;
                     mdl_d        = scan_r_q;
                     scan_valid_d = 1'b1;
                  end else begin
                     lock_cnt_d = lock_cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d      = ST_IDLE;
               presc_d      = '0;
               lock_cnt_d   = '0;
               mdc_d        = 3'd0;
               mdl_d        = 3'd0;
               scan_valid_d = 1'b0;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         presc_q      <= '0;
         lock_cnt_q   <= '0;
         scan_c_q     <= 3'd0;
         scan_r_q     <= 3'd0;
         mdc_q        <= 3'd0;
         mdl_q        <= 3'd0;
         cur_c_q      <= 3'd0;
         cur_r_q      <= 3'd0;
         scan_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         sel_ack_q    <= 1'b0;
         sel_pend_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         lock_cnt_q   <= lock_cnt_d;
         scan_c_q     <= scan_c_d;
         scan_r_q     <= scan_r_d;
         mdc_q        <= mdc_d;
         mdl_q        <= mdl_d;
         cur_c_q      <= cur_c_d;
         cur_r_q      <= cur_r_d;
         scan_valid_q <= scan_valid_d;
         frame_done_q <= frame_done_d;
         sel_ack_q    <= sel_ack_d;
         sel_pend_q   <= sel_pend_d;
      end
   end

   assign mdc        = mdc_q;
   assign mdl        = mdl_q;
   assign cur_c      = cur_c_q;
   assign cur_r      = cur_r_q;
   assign scan_valid = scan_valid_q;
   assign frame_done = frame_done_q;
   assign sel_ack    = sel_ack_q;
   assign locked     = (state_q == ST_LOCK);

endmodule

// File: tb/tb_coord_scan_ctrl.sv
// tb_coord_scan_ctrl: directed scoreboard bench for coord_scan_ctrl (DIV=4, 5x7 matrix, LOCK_TK=4).
module tb_coord_scan_ctrl;

   localparam int N_COL   = 5;
   localparam int N_ROW   = 7;
   localparam int DIV     = 4;
   localparam int LOCK_TK = 4;
   localparam int CELLS   = N_COL * N_ROW;
   localparam int FRAME   = CELLS * DIV;
   localparam int LOCK_CY = LOCK_TK * DIV;

`ifdef CURSOR_WRAP_EN
   localparam int EDGE_C = 0;
   localparam int EDGE_R = 6;
`else
   localparam int EDGE_C = 4;
   localparam int EDGE_R = 0;
`endif

   localparam logic [15:0] M_ALL   = 16'hFFFF;
   localparam logic [15:0] M_CUR   = 16'h03F0;
   localparam logic [15:0] M_NO_FD = 16'h03FB;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic en = 1'b0;
   logic btn_up = 1'b0, btn_dn = 1'b0, btn_lf = 1'b0, btn_rt = 1'b0;
   logic sel_req = 1'b0;
   logic [2:0] mdc, mdl, cur_c, cur_r;
   logic scan_valid, frame_done, sel_ack, locked;
   logic [15:0] obs;

   int n_assert = 0;
   int n_fail   = 0;
   int k        = 0;
   int base     = 0;
   int mark     = 0;
   int fd_count = 0;

   typedef struct {
      string       tag;
      logic [15:0] exp;
      logic [15:0] mask;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   coord_scan_ctrl #(
      .N_COL(N_COL), .N_ROW(N_ROW), .DIV(DIV), .LOCK_TK(LOCK_TK)
   ) dut (
      .clk(clk), .reset_n(reset_n), .en(en),
      .btn_up(btn_up), .btn_dn(btn_dn), .btn_lf(btn_lf), .btn_rt(btn_rt),
      .sel_req(sel_req),
      .mdc(mdc), .mdl(mdl), .cur_c(cur_c), .cur_r(cur_r),
      .scan_valid(scan_valid), .frame_done(frame_done),
      .sel_ack(sel_ack), .locked(locked)
   );

   assign obs = {mdc, mdl, cur_c, cur_r, scan_valid, frame_done, sel_ack, locked};

   function automatic logic [15:0] pk(input int c, input int r, input int cc, input int cr,
                                      input logic sv, input logic fd, input logic ack,
                                      input logic lk);
      return {3'(c), 3'(r), 3'(cc), 3'(cr), sv, fd, ack, lk};
   endfunction

   task automatic push(input string tag, input logic [15:0] exp, input logic [15:0] mask);
      exp_t e;
      e.tag  = tag;
      e.exp  = exp;
      e.mask = mask;
      sb.push_back(e);
   endtask

   task automatic check_top();
      exp_t e;
      n_assert++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty observed=%h required=entry", obs);
      end else begin
         e = sb.pop_front();
         assert ((obs & e.mask) === (e.exp & e.mask)) else begin
            n_fail++;
            $error("FAIL %s observed=%h required=%h", e.tag, obs & e.mask, e.exp & e.mask);
         end
      end
   endtask

   task automatic clk_step();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic step_expect(input string tag, input logic [15:0] exp, input logic [15:0] mask);
      push(tag, exp, mask);
      clk_step();
      check_top();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) clk_step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, then IDLE with en low.
      #12;
      push("reset_outputs", 16'h0000, M_ALL);
      check_top();
      reset_n = 1'b1;
      step_expect("idle_en_low", 16'h0000, M_ALL);

      // Enable: scan starts at (0,0).
      en = 1'b1;
      step_expect("scan_start", pk(0, 0, 0, 0, 1, 0, 0, 0), M_ALL);
      base = k;

      // One full frame plus one cell: raster order, frame_done only when leaving (4,6).
      for (int j = 1; j <= FRAME + DIV; j++) begin
         int idx;
         idx = (j / DIV) % CELLS;
         push("raster", pk(idx % N_COL, idx / N_COL, 0, 0, 1, (j % FRAME) == 0, 0, 0), M_ALL);
         clk_step();
         if (frame_done) fd_count++;
         check_top();
      end
      push("frame_done_count", 16'd1, M_ALL);
      n_assert++;
      assert ({15'd0, 1'b0} + 16'(fd_count) === sb[0].exp) else begin
         n_fail++;
         $error("FAIL frame_done_count observed=%0d required=1", fd_count);
      end
      void'(sb.pop_front());

      // Cursor moves while scanning; up+rt together applies only up.
      btn_rt = 1'b1; clk_step(); clk_step(); btn_rt = 1'b0;
      btn_dn = 1'b1; clk_step(); clk_step(); clk_step(); btn_dn = 1'b0;
      push("cursor_2_3", pk(0, 0, 2, 3, 0, 0, 0, 0), M_CUR);
      check_top();
      btn_up = 1'b1; btn_rt = 1'b1;
      step_expect("priority_up_over_rt", pk(0, 0, 2, 2, 0, 0, 0, 0), M_CUR);
      btn_up = 1'b0; btn_rt = 1'b0;
      btn_dn = 1'b1;
      step_expect("cursor_back_2_3", pk(0, 0, 2, 3, 0, 0, 0, 0), M_CUR);
      btn_dn = 1'b0;

      // Confirm while the scan shows (1,5): cell 26, prescaler mid-count.
      while (((k - base) % FRAME) != 26 * DIV + 1) clk_step();
      sel_req = 1'b1;
      step_expect("lock_entry", pk(2, 3, 2, 3, 0, 0, 1, 1), M_ALL);
      mark = k;
      btn_dn = 1'b1;
      step_expect("lock_ignores_sel_btn", pk(2, 3, 2, 3, 0, 0, 0, 1), M_ALL);
      btn_dn = 1'b0; sel_req = 1'b0;
      run(mark + LOCK_CY - 1 - k);
      push("lock_last_cycle", pk(2, 3, 2, 3, 0, 0, 0, 1), M_ALL);
      check_top();
      step_expect("resume_1_5", pk(1, 5, 2, 3, 1, 0, 0, 0), M_ALL);
      base = k - 26 * DIV;
      run(DIV - 1);
      push("resume_hold_1_5", pk(1, 5, 2, 3, 1, 0, 0, 0), M_ALL);
      check_top();
      step_expect("resume_adv_2_5", pk(2, 5, 2, 3, 1, 0, 0, 0), M_ALL);

      // Confirm coincident with the tick leaving (4,6): LOCK wins, no frame_done.
      while (((k - base) % FRAME) != FRAME - 1) clk_step();
      sel_req = 1'b1;
      step_expect("lock_on_tick", pk(2, 3, 2, 3, 0, 0, 1, 1), M_ALL);
      sel_req = 1'b0;
      mark = k;
      run(mark + LOCK_CY - 1 - k);
      step_expect("reshow_4_6", pk(4, 6, 2, 3, 1, 0, 0, 0), M_ALL);
      run(DIV - 1);
      push("reshow_hold_4_6", pk(4, 6, 2, 3, 1, 0, 0, 0), M_ALL);
      check_top();
      step_expect("wrap_after_lock", pk(0, 0, 2, 3, 1, 1, 0, 0), M_ALL);

      // Confirm together with a move: move first, LOCK one cycle later on the moved cursor.
      sel_req = 1'b1; btn_lf = 1'b1;
      step_expect("sel_btn_move_first", pk(0, 0, 1, 3, 1, 0, 0, 0), M_NO_FD);
      sel_req = 1'b0; btn_lf = 1'b0;
      step_expect("sel_btn_lock_late", pk(1, 3, 1, 3, 0, 0, 1, 1), M_ALL);

      // Drop en mid-LOCK.
      run(4);
      en = 1'b0;
      step_expect("en_low_in_lock", pk(0, 0, 1, 3, 0, 0, 0, 0), M_ALL);
      step_expect("idle_hold", pk(0, 0, 1, 3, 0, 0, 0, 0), M_ALL);

      // Cursor edge behaviour, exercised in IDLE.
      btn_rt = 1'b1; run(3); btn_rt = 1'b0;
      btn_up = 1'b1; run(3); btn_up = 1'b0;
      push("cursor_4_0", pk(0, 0, 4, 0, 0, 0, 0, 0), M_ALL);
      check_top();
      btn_rt = 1'b1;
      step_expect("edge_rt", pk(0, 0, EDGE_C, 0, 0, 0, 0, 0), M_ALL);
      btn_rt = 1'b0;
      btn_up = 1'b1;
      step_expect("edge_up", pk(0, 0, EDGE_C, EDGE_R, 0, 0, 0, 0), M_ALL);
      btn_up = 1'b0;

      // Restart scanning, then async reset mid-frame without a clock edge.
      en = 1'b1;
      step_expect("restart_scan", pk(0, 0, EDGE_C, EDGE_R, 1, 0, 0, 0), M_ALL);
      run(DIV + 2);
      push("scan_after_restart", pk(1, 0, EDGE_C, EDGE_R, 1, 0, 0, 0), M_ALL);
      check_top();
      #2;
      reset_n = 1'b0;
      #1;
      push("async_reset", 16'h0000, M_ALL);
      check_top();
      clk_step();
      push("reset_held", 16'h0000, M_ALL);
      check_top();
      reset_n = 1'b1;
      en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
